serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
- Built from a single 1-bit full-subtractor cell plus a registered borrow, so it is the sequential stage that consumes the full-subtractor cell.
- Takes parallel operands with a start/ready handshake and returns the parallel difference and final borrow with a one-cycle valid pulse.
- Used wherever area matters more than latency: multi-cycle datapaths and divider remainder steps.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- borrow_in  input  1  initial borrow; latched on accepted start.
- ready  output  1  block can accept start (state IDLE or DONE).
- busy  output  1  subtraction in progress (state RUN).
- diff  output  WIDTH  result a-b-borrow_in mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow; held with diff.
- valid  output  1  one-cycle pulse when diff/borrow_out become new.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a/b shift registers, diff, borrow register, counter, borrow_out and valid all 0. Outputs during reset: ready=1, busy=0.
- States: IDLE, RUN, DONE. Outputs: ready=(state!=RUN), busy=(state==RUN), valid=(state==DONE); all registered-state decodes.
- IDLE: start=1 latches a, b and borrow_in; clears counter and diff; goes to RUN. start=0 stays in IDLE.
- RUN, each edge:
  - Cell computes d = a_sh[0]^b_sh[0]^br and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - diff shifts right with d entering at the MSB; a_sh and b_sh shift right; br<=bo; counter++.
  - When counter reaches WIDTH-1 on this edge, go to DONE and load borrow_out<=bo.
- Latency: start accepted at edge 0; bits processed at edges 1..WIDTH; valid=1 in the cycle after edge WIDTH; busy high for exactly WIDTH cycles.
- DONE: lasts one cycle.
  - start=1 is accepted exactly as in IDLE, giving back-to-back operation with no idle gap; diff is cleared only at that point, so it stays readable during the valid cycle.
  - Otherwise go to IDLE.
- start while busy is ignored: no queuing, no error flag, and operands are not re-sampled.
- a, b and borrow_in may change freely after acceptance.
- Reset mid-RUN aborts immediately to the reset values; no valid is produced for the aborted operation.
- Arithmetic is modulo 2^WIDTH. borrow_out=1 iff a < b+borrow_in (unsigned). No signed overflow flag.
- X-free: a start of X during IDLE is a bench error; no special handling in RTL.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module, full_subtractor_cell: purely combinational 1-bit a, b, bin -> d, bout, instantiated once inside serial_subtractor.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, borrow_in=0, start pulse -> busy for 8 cycles, then valid pulse with diff=0x1E, borrow_out=0.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Then a=0x10, b=0x10, borrow_in=1 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0x00, borrow_in=1 -> diff=0xFE, borrow_out=0.
- Start 0x5A-0x3C, then assert start with a=0x00, b=0xFF on cycle 3 of RUN -> ignored; result 0x1E/0, ready=0 throughout RUN.
- start held high continuously with 0x80-0x01 then 0x01-0x02 -> second accepted in the DONE cycle; valids exactly 9 cycles apart with 0x7F/0 then 0xFF/1.
- Drop rst_n at cycle 4 of RUN -> outputs reset asynchronously (diff=0, busy=0, ready=1), no valid. After release, 0x33-0x11 -> 0x22/0.
- Exhaustive sweep at WIDTH=4 over all a, b and borrow_in -> every diff/borrow_out matches the (a-b-borrow_in) reference model; exactly one valid per accepted start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared constants for the bit-serial subtractor:
//     - default operand width
//     - FSM state encoding (kept as plain 2-bit constants so the encoding is
//       fixed and stable across tools and netlists)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_subtractor_cell
//   Purely combinational 1-bit full subtractor: computes a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  incoming borrow
//     d    out 1  difference bit
//     bout out 1  outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits are equal and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, built from a
//   single full_subtractor_cell plus a registered borrow.
//   Ports:
//     clk        in  1      rising-edge clock
//     rst_n      in  1      asynchronous active-low reset
//     start      in  1      request, sampled only while ready=1
//     a          in  WIDTH  minuend, latched on accepted start
//     b          in  WIDTH  subtrahend, latched on accepted start
//     borrow_in  in  1      initial borrow, latched on accepted start
//     ready      out 1      can accept start (IDLE or DONE)
//     busy       out 1      subtraction in progress (RUN)
//     diff       out WIDTH  a - b - borrow_in mod 2^WIDTH, held until next start
//     borrow_out out 1      final borrow, held with diff
//     valid      out 1      one-cycle pulse when diff/borrow_out are new
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             valid
);

  logic [1:0]       state_q,      state_d;
  logic [WIDTH-1:0] a_sh_q,       a_sh_d;
  logic [WIDTH-1:0] b_sh_q,       b_sh_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             br_q,         br_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             borrow_out_q, borrow_out_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_d       = diff_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // diff is cleared only here, so the previous result stays readable
          // through the DONE (valid) cycle even on back-to-back starts.
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at LSB.
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = ST_DONE;
          borrow_out_d = cell_bo;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_q       <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_q       <= diff_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign ready      = (state_q != ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign valid      = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench: one WIDTH=8 and one WIDTH=4 instance, a behavioural
//   result/latency model, a per-cycle compare process and directed literal
//   checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0 -> WIDTH=8 instance, index 1 -> WIDTH=4 instance.
  logic       start_s [2];
  logic [7:0] a_s     [2];
  logic [7:0] b_s     [2];
  logic       bin_s   [2];

  logic       rdy8, bsy8, vld8, bo8;
  logic [7:0] diff8;
  logic       rdy4, bsy4, vld4, bo4;
  logic [3:0] diff4;

  logic       ready_w [2];
  logic       busy_w  [2];
  logic       valid_w [2];
  logic       bo_w    [2];
  logic [7:0] diff_w  [2];

  always_comb begin
    ready_w[0] = rdy8;  ready_w[1] = rdy4;
    busy_w[0]  = bsy8;  busy_w[1]  = bsy4;
    valid_w[0] = vld8;  valid_w[1] = vld4;
    bo_w[0]    = bo8;   bo_w[1]    = bo4;
    diff_w[0]  = diff8; diff_w[1]  = {4'b0, diff4};
  end

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .borrow_in(bin_s[0]), .ready(rdy8), .busy(bsy8), .diff(diff8),
    .borrow_out(bo8), .valid(vld8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1][3:0]), .b(b_s[1][3:0]),
    .borrow_in(bin_s[1]), .ready(rdy4), .busy(bsy4), .diff(diff4),
    .borrow_out(bo4), .valid(vld4)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted start yields (a-b-bin) mod 2^W after W busy
  // cycles, then one valid cycle; starts during the busy window are dropped.
  // ---------------------------------------------------------------------------
  int         left      [2];
  logic       exp_valid [2];
  logic [7:0] exp_diff  [2];
  logic       exp_bo    [2];
  logic [7:0] pend_diff [2];
  logic       pend_bo   [2];
  int         acc_cnt   [2];
  int         val_cnt   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; bin_s[i] = 1'b0;
      acc_cnt[i] = 0; val_cnt[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin : model
    int av, bv, bi, mask;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        left[i] = 0; exp_valid[i] = 1'b0; exp_diff[i] = '0; exp_bo[i] = 1'b0;
      end else begin
        exp_valid[i] = 1'b0;
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) begin
            exp_valid[i] = 1'b1;
            exp_diff[i]  = pend_diff[i];
            exp_bo[i]    = pend_bo[i];
          end
        end else if (start_s[i]) begin
          mask = (1 << wd(i)) - 1;
          av = int'(a_s[i]) & mask;
          bv = int'(b_s[i]) & mask;
          bi = int'(bin_s[i]);
          pend_diff[i] = 8'((av - bv - bi) & mask);
          pend_bo[i]   = (av < bv + bi);
          left[i]      = wd(i);
          exp_diff[i]  = '0;
          acc_cnt[i]++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w%0d.ready", wd(i)), 32'(ready_w[i]), 32'(left[i] == 0));
      chk($sformatf("w%0d.busy",  wd(i)), 32'(busy_w[i]),  32'(left[i] > 0));
      chk($sformatf("w%0d.valid", wd(i)), 32'(valid_w[i]), 32'(exp_valid[i]));
      if (left[i] == 0) begin
        chk($sformatf("w%0d.diff", wd(i)),       32'(diff_w[i]), 32'(exp_diff[i]));
        chk($sformatf("w%0d.borrow_out", wd(i)), 32'(bo_w[i]),   32'(exp_bo[i]));
      end
      if (valid_w[i]) val_cnt[i]++;
    end
  end

  // Wait (bounded) at negedges for valid; returns the sampled result.
  task automatic wait_valid(input int idx, input string nm, output logic [7:0] d,
                            output logic bo, output int vcyc, output int busy_n);
    int n = 0;
    busy_n = 0;
    while (n < 40 && !valid_w[idx]) begin
      if (busy_w[idx]) busy_n++;
      @(negedge clk);
      n++;
    end
    if (!valid_w[idx]) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s.timeout: got no valid expected valid within 40 cycles", nm);
    end
    d = diff_w[idx]; bo = bo_w[idx]; vcyc = cyc;
  endtask

  // One isolated operation with a hand-computed (or plain-arithmetic) expectation.
  task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb, input string nm);
    logic [7:0] d; logic bo; int vc, bn;
    @(negedge clk);
    a_s[idx] = av; b_s[idx] = bv; bin_s[idx] = bi; start_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
    wait_valid(idx, nm, d, bo, vc, bn);
    chk({nm, ".diff"}, 32'(d), 32'(ed));
    chk({nm, ".borrow_out"}, 32'(bo), 32'(eb));
    chk({nm, ".busy_cycles"}, 32'(bn), 32'(wd(idx)));
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d; logic bo; int v1, v2, bn, vstart;
    // Reset values while rst_n is low.
    #1;
    chk("rst.ready", 32'(rdy8), 32'd1);
    chk("rst.busy",  32'(bsy8), 32'd0);
    chk("rst.valid", 32'(vld8), 32'd0);
    chk("rst.diff",  32'(diff8), 32'd0);
    chk("rst.borrow_out", 32'(bo8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t1_5A_3C");
    do_op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2_00_01");
    do_op(0, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "t2_10_10_b1");
    do_op(0, 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, "t2_FF_00_b1");

    // Start during RUN must be ignored.
    @(negedge clk);
    a_s[0] = 8'h5A; b_s[0] = 8'h3C; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_s[0] = 8'h00; b_s[0] = 8'hFF; start_s[0] = 1'b1;
    chk("t3.ready_in_run", 32'(rdy8), 32'd0);
    @(negedge clk); start_s[0] = 1'b0;
    wait_valid(0, "t3", d, bo, v1, bn);
    chk("t3.diff", 32'(d), 32'h1E);
    chk("t3.borrow_out", 32'(bo), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a_s[0] = 8'h80; b_s[0] = 8'h01; bin_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk);
    a_s[0] = 8'h01; b_s[0] = 8'h02;
    wait_valid(0, "t4a", d, bo, v1, bn);
    chk("t4a.diff", 32'(d), 32'h7F);
    chk("t4a.borrow_out", 32'(bo), 32'd0);
    @(negedge clk);
    wait_valid(0, "t4b", d, bo, v2, bn);
    start_s[0] = 1'b0;
    chk("t4b.diff", 32'(d), 32'hFF);
    chk("t4b.borrow_out", 32'(bo), 32'd1);
    chk("t4.valid_spacing", 32'(v2 - v1), 32'd9);
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    a_s[0] = 8'h5A; b_s[0] = 8'h3C; start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.diff",  32'(diff8), 32'd0);
    chk("t5.busy",  32'(bsy8),  32'd0);
    chk("t5.ready", 32'(rdy8),  32'd1);
    chk("t5.valid", 32'(vld8),  32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t5.no_valid", 32'(vld8), 32'd0);
    end
    do_op(0, 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, "t5_33_11");

    // Randomized traffic on the 8-bit instance; model compare checks it.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start_s[0] = ($urandom_range(0, 3) == 0);
      a_s[0]     = 8'($urandom);
      b_s[0]     = 8'($urandom);
      bin_s[0]   = 1'($urandom);
    end
    @(negedge clk); start_s[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive sweep at WIDTH=4.
    vstart = val_cnt[1];
    v1 = acc_cnt[1];
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bi = 0; bi < 2; bi++)
          do_op(1, 8'(av), 8'(bv), 1'(bi), 8'((av - bv - bi) & 15),
                1'(av < bv + bi), $sformatf("sw4_%0h_%0h_%0d", av, bv, bi));
    repeat (3) @(negedge clk);
    chk("sw4.accepts", 32'(acc_cnt[1] - v1), 32'd512);
    chk("sw4.valids",  32'(val_cnt[1] - vstart), 32'd512);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
